// File: rtl/fp_fflags_commit_buffer.sv
// In-order commit buffer for FP exception flags: entries are allocated at dispatch,
// filled at writeback in any order, and OR-ed into the architectural fflags at commit.
module fp_fflags_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [4:0]       wb_fflags,
  input  logic             commit_valid,
  output logic             commit_ready,
  input  logic             flush,
  input  logic             csr_we,
  input  logic [4:0]       csr_wdata,
  output logic [4:0]       fflags,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]   head;
  logic [TAG_W:0]   tail;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;

  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_done;
  logic [4:0]       entry_flags [DEPTH];

  logic             alloc_fire;
  logic             commit_fire;
  logic             wb_fire;
  logic [4:0]       head_flags;

  assign head_idx   = head[TAG_W-1:0];
  assign tail_idx   = tail[TAG_W-1:0];
  assign count      = tail - head;
  assign alloc_tag  = tail_idx;
  assign head_flags = entry_flags[head_idx];

  // Handshakes: a transfer happens on a clock edge where valid and ready are both
  // high; ready never depends on the matching valid, and a requester holds valid
  // until it sees ready. alloc and commit follow this; wb is fire-and-forget.
  assign alloc_ready  = (count != FULL_COUNT) && !flush;
  assign commit_ready = entry_valid[head_idx] && entry_done[head_idx];

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = commit_valid && commit_ready;
  assign wb_fire     = wb_valid && entry_valid[wb_tag] && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (commit_fire) begin
        head <= head + 1'b1;
      end
      // Flush drops everything younger than the (possibly just-advanced) head.
      if (flush) begin
        tail <= commit_fire ? head + 1'b1 : head;
      end else if (alloc_fire) begin
        tail <= tail + 1'b1;
      end
    end
  end

  // Later assignments win: commit clears after writeback, alloc overrides both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_valid <= '0;
      entry_done  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_flags[i] <= '0;
      end
    end else if (flush) begin
      entry_valid <= '0;
      entry_done  <= '0;
    end else begin
      if (wb_fire) begin
        entry_done[wb_tag]  <= 1'b1;
        entry_flags[wb_tag] <= wb_fflags;
      end
      if (commit_fire) begin
        entry_valid[head_idx] <= 1'b0;
        entry_done[head_idx]  <= 1'b0;
      end
      if (alloc_fire) begin
        entry_valid[tail_idx] <= 1'b1;
        entry_done[tail_idx]  <= 1'b0;
        entry_flags[tail_idx] <= '0;
      end
    end
  end

  // A CSR write in the same cycle as a commit is older, so the committed flags land on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags <= '0;
    end else if (csr_we) begin
      fflags <= csr_wdata | (commit_fire ? head_flags : 5'b0);
    end else if (commit_fire) begin
      fflags <= fflags | head_flags;
    end
  end

endmodule

// File: tb/tb_fp_fflags_commit_buffer.sv
// Directed bench for fp_fflags_commit_buffer with hand-computed expectations.
module tb_fp_fflags_commit_buffer;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [4:0]       wb_fflags;
  logic             commit_valid;
  logic             commit_ready;
  logic             flush;
  logic             csr_we;
  logic [4:0]       csr_wdata;
  logic [4:0]       fflags;
  logic [TAG_W:0]   count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_fflags_commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_fflags    (wb_fflags),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .flush        (flush),
    .csr_we       (csr_we),
    .csr_wdata    (csr_wdata),
    .fflags       (fflags),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1-2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid  = 1'b0;
    wb_valid     = 1'b0;
    wb_tag       = '0;
    wb_fflags    = '0;
    commit_valid = 1'b0;
    flush        = 1'b0;
    csr_we       = 1'b0;
    csr_wdata    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic wb(input logic [TAG_W-1:0] tag, input logic [4:0] f);
    wb_valid  = 1'b1;
    wb_tag    = tag;
    wb_fflags = f;
    step();
    wb_valid  = 1'b0;
    #1;
  endtask

  initial begin
    // ---- reset state
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_commit_ready", commit_ready, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_alloc_tag", alloc_tag, 0);

    // ---- alloc 3, out-of-order writeback, in-order commit
    alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("alloc_tag_seq", alloc_tag, i);
      step();
    end
    alloc_valid = 1'b0;
    #1;
    chk("count_3", count, 3);
    chk("cr_not_done", commit_ready, 0);
    wb(3'd1, 5'b00001);
    chk("cr_head_pending", commit_ready, 0);
    wb_valid = 1'b1; wb_tag = 3'd0; wb_fflags = 5'b10000;
    #1;
    chk("cr_no_bypass", commit_ready, 0);
    step();
    wb_valid = 1'b0;
    #1;
    chk("cr_head_done", commit_ready, 1);
    wb(3'd2, 5'b00000);
    commit_valid = 1'b1;
    step(); #1;
    chk("fflags_c1", fflags, 5'b10000);
    step(); #1;
    chk("fflags_c2", fflags, 5'b10001);
    step();
    commit_valid = 1'b0;
    #1;
    chk("fflags_c3", fflags, 5'b10001);
    chk("count_drained", count, 0);
    chk("cr_empty", commit_ready, 0);

    // ---- fill to DEPTH, overflow ignored, wrap
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    #1;
    chk("full_count", count, 8);
    chk("full_alloc_ready", alloc_ready, 0);
    step(); #1;
    chk("full_ignored", count, 8);
    alloc_valid = 1'b0;
    wb(3'd0, 5'b00000);
    commit_valid = 1'b1;
    #1;
    chk("full_no_bypass", alloc_ready, 0);
    step();
    commit_valid = 1'b0;
    #1;
    chk("free_alloc_ready", alloc_ready, 1);
    chk("free_count", count, 7);
    chk("wrap_tag", alloc_tag, 0);
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    #1;
    chk("refull_count", count, 8);

    // ---- CSR write vs commit
    do_reset();
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    wb(3'd0, 5'b00100);
    commit_valid = 1'b1; csr_we = 1'b1; csr_wdata = 5'b00001;
    step();
    commit_valid = 1'b0; csr_we = 1'b0;
    #1;
    chk("csr_commit_merge", fflags, 5'b00101);
    csr_we = 1'b1; csr_wdata = 5'b01010;
    step(); #1;
    chk("csr_write", fflags, 5'b01010);
    csr_wdata = 5'b00000;
    step();
    csr_we = 1'b0;
    #1;
    chk("csr_clear", fflags, 0);

    // ---- flush with same-cycle commit (head=tail=1)
    alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    alloc_valid = 1'b0;
    wb(3'd1, 5'b01000);
    wb(3'd2, 5'b00010);
    wb(3'd3, 5'b10000);
    wb(3'd4, 5'b00001);
    commit_valid = 1'b1; flush = 1'b1; alloc_valid = 1'b1;
    #1;
    chk("flush_alloc_ready", alloc_ready, 0);
    step();
    idle();
    #1;
    chk("flush_fflags", fflags, 5'b01000);
    chk("flush_count", count, 0);
    chk("flush_cr", commit_ready, 0);
    chk("flush_tail", alloc_tag, 2);
    wb(3'd2, 5'b10000);
    chk("wb_flushed_cr", commit_ready, 0);
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    #1;
    chk("realloc_cr", commit_ready, 0);
    wb(3'd2, 5'b00000);
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    #1;
    chk("realloc_fflags", fflags, 5'b01000);
    csr_we = 1'b1; csr_wdata = 5'b00000;
    step();
    csr_we = 1'b0;
    #1;

    // ---- writeback to never-allocated tag 5 (head=tail=3)
    wb(3'd5, 5'b10000);
    chk("ghost_count", count, 0);
    alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    alloc_valid = 1'b0;
    wb(3'd3, 5'b00000);
    wb(3'd4, 5'b00000);
    commit_valid = 1'b1;
    step(); step();
    commit_valid = 1'b0;
    #1;
    chk("ghost_not_done", commit_ready, 0);
    wb(3'd5, 5'b00000);
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    #1;
    chk("ghost_fflags", fflags, 0);
    chk("ghost_count_end", count, 0);

    // ---- asynchronous reset mid-stream (head=tail=6)
    alloc_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    alloc_valid = 1'b0;
    csr_we = 1'b1; csr_wdata = 5'b01000;
    step();
    csr_we = 1'b0;
    wb(3'd6, 5'b00010);
    chk("pre_rst_count", count, 5);
    chk("pre_rst_fflags", fflags, 5'b01000);
    chk("pre_rst_cr", commit_ready, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_fflags", fflags, 0);
    chk("async_rst_cr", commit_ready, 0);
    step();
    rst = 1'b0;
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_fflags_commit_buffer.md
Name: fp_fflags_commit_buffer

Overview:
In-order buffer that collects the exception flags (NV, DZ, OF, UF, NX) that the FP execution pipelines (other/conversion, add, mul, div) report at writeback, and folds them into the architectural fflags register only when the owning instruction commits. It is the consumer end of the FP pipelines' fflags output. Entries are allocated at dispatch in program order, filled out of order at writeback, retired from the head at commit, and discarded on pipeline flush. It also services CSR writes to fflags.

Parameters:
DEPTH, 8, number of in-flight FP instructions tracked; power of two, 2..32
TAG_W, $clog2(DEPTH), entry tag width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
alloc_valid  in  1  dispatch requests one entry
alloc_ready  out  1  entry available (combinational: not full and not flush)
alloc_tag  out  TAG_W  tag of the entry allocated this cycle (tail pointer)
wb_valid  in  1  an FP pipeline delivers flags
wb_tag  in  TAG_W  entry being written back
wb_fflags  in  5  FFlags_Path {NV,DZ,OF,UF,NX}
commit_valid  in  1  commit stage requests retirement of the oldest FP instruction
commit_ready  out  1  head is allocated and written back (combinational)
flush  in  1  discard all uncommitted entries
csr_we  in  1  software write of fflags
csr_wdata  in  5  value written
fflags  out  5  architectural accumulated flags (registered)
count  out  TAG_W+1  occupied entries

Behaviour:
- Reset (async, rst=1): head=tail=0, count=0, all valid/done bits 0, fflags=0. alloc_ready=1 and commit_ready=0 once rst deasserts.
- Pointers carry one extra wrap bit internally. Full when count==DEPTH; empty when count==0. Index = pointer[TAG_W-1:0]; wrap from DEPTH-1 to 0 is seamless.
- Alloc: on alloc_valid & alloc_ready at a clock edge, entry[tail] gets valid=1, done=0, flags=0, and tail increments. alloc_tag is valid in the same cycle as the request. Alloc while alloc_ready=0 is ignored.
- Writeback: on wb_valid, if entry[wb_tag] is valid, it gets done=1 and flags=wb_fflags, taking effect next cycle. A writeback to an invalid entry is ignored silently. A repeated writeback to a done entry overwrites its flags.
- Commit: on commit_valid & commit_ready, entry[head] is cleared, head increments, and fflags <= fflags | entry[head].flags. commit_valid while commit_ready=0 has no effect; the commit stage holds the request.
- commit_ready does not bypass: a writeback to the head is visible to commit_ready one cycle later.
- Same-cycle alloc and commit: both take effect and count is unchanged. When full, commit frees a slot one cycle later; alloc_ready is not bypassed.
- Same-cycle writeback and alloc to the same index cannot occur, because the index is invalid until allocated. If it does occur, alloc wins.
- CSR write: fflags <= csr_wdata. If a commit occurs in the same cycle, fflags <= csr_wdata | head.flags, because the CSR instruction is older.
- Flush: all entries are invalidated, tail <= head, and count <= 0 at the next edge. A same-cycle alloc is dropped (alloc_ready=0 during flush) and a same-cycle writeback is dropped. A same-cycle commit is still performed first, so head advances and fflags accumulates; tail is then set to the new head. fflags is never cleared by flush.
- Reset asserted mid-operation clears everything immediately. Partially accumulated flags are lost by design.
- Flags are sticky: only a CSR write can clear a bit.
- Latency: writeback to commit-eligible is 1 cycle. Commit to fflags visible is 1 cycle.

Test Plan:
- Reset, then alloc 3 (tags 0,1,2); writeback tag1=NX (5'b00001), tag0=NV (5'b10000), tag2=0; commit 3 times -> commit_ready rises only after tag0 is done; fflags=5'b10001; count returns to 0.
- Alloc DEPTH=8 -> alloc_ready=0 and count=8; a 9th alloc is ignored; writeback and commit tag0 -> alloc_ready=1 the next cycle; the next alloc_tag=0 (wrap).
- Same cycle: commit head with flags OF (5'b00100) and csr_we with csr_wdata=5'b00001 -> fflags=5'b00101. A later csr_we with 0 -> fflags=0.
- Alloc 4 with writebacks done, assert flush together with commit_valid -> exactly one entry committed and its flags accumulated; count=0; a later writeback to a flushed tag does not change commit_ready.
- Writeback to a never-allocated tag 5 with NV, then alloc up to tag 5 and commit through it with zero flags -> fflags NV stays 0.
- Assert rst asynchronously mid-stream with count=5 and fflags=5'b01000 -> count=0, fflags=0, commit_ready=0 before the next clk edge.
